instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Holds the program counter, issues instruction-memory reads and presents the fetched instruction word to the decode stage (control decoder and immediate generator). It selects the next PC from PC+4, PC+Immediate (taken branch / JAL) or the JALR target produced by the ALU. One instruction is in flight at a time; the core consumes an instruction by deasserting `Stall` while `InstrValid` is high.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `PCSel`  input  2  next-PC select: 00 PC+4, 01 PC+Immediate, 10 JALR, 11 reserved (behaves as 00).
- `Immediate`  input  32  sign-extended offset from the immediate generator.
- `JalrTarget`  input  32  rs1+imm from the ALU.
- `Stall`  input  1  core not ready to retire the current instruction.
- `IMemReq`  output  1  one-cycle read request pulse.
- `IMemAddr`  output  32  read address, equals `PC`.
- `IMemValid`  input  1  read data valid.
- `IMemRData`  input  32  read data.
- `Instruction`  output  32  registered instruction word to decode.
- `InstrValid`  output  1  `Instruction` is valid for the current `PC`.
- `PC`  output  32  address of the current instruction.
- `PCPlus4`  output  32  PC+4, for JAL/JALR link writeback.
- `MisalignFault`  output  1  sticky; a redirect target was not 4-byte aligned.

## Operation
- States: IDLE, REQ, WAIT, VALID, HALT.
- IDLE: entered on reset; next cycle go to REQ.
- REQ: `IMemReq`=1 for exactly one cycle, `IMemAddr`=PC; go to WAIT.
- WAIT: on `IMemValid`, register `IMemRData` into `Instruction`, go to VALID; otherwise remain. `IMemValid` is ignored in every state other than WAIT.
- VALID: `InstrValid`=1. If `Stall`=1, hold everything. If `Stall`=0, retire: compute the next PC, update `PC`, go to REQ.
- Next PC: 00/11 → PC+4; 01 → PC+Immediate; 10 → {JalrTarget[31:1],1'b0}. All sums are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Alignment: if the selected next PC has bits[1:0]≠0, `PC` is not updated, `MisalignFault` is set, and the state goes to HALT.
- HALT: no requests; `InstrValid`=0; only reset leaves this state.
- `PCPlus4` = PC+4, combinational from the `PC` register.
- `Instruction` keeps its last value outside VALID.

## Timing
- Reset values: PC=RESET_PC, Instruction=32'h0000_0013 (NOP), InstrValid=0, IMemReq=0, MisalignFault=0, state IDLE.
- First `IMemReq` occurs in the second rising edge after `reset` deasserts (IDLE→REQ).
- `IMemValid` may arrive 1 or more cycles after the `IMemReq` cycle. `InstrValid` rises the cycle after `IMemValid` is sampled.
- Minimum 3 cycles per instruction (REQ, WAIT, VALID) with zero-wait memory.
- Redirect takes effect at the retiring edge. The new PC is visible on `IMemAddr` in the following REQ cycle.
- `PCSel`, `Immediate` and `JalrTarget` are sampled only on the retiring edge (VALID && !Stall).
- Reset asserted in any state, including mid-WAIT, forces reset values immediately. Instruction memory shares `reset`, so no stale response returns after reset.

## Structure
- Shared package `riscv_pkg` holds:
  - `pc_sel_e` enum (PC_PLUS4, PC_IMM, PC_JALR, PC_RSVD);
  - `fetch_state_e`;
  - constant `NOP_INSTR` = 32'h0000_0013.
- One combinational sub-module `pc_next_mux` computes the next PC and the alignment flag. The state machine and registers stay in the top level.

## Test plan
- Reset with RESET_PC=32'h0000_0100 and 1-cycle memory → IMemReq with IMemAddr=0x100 two cycles after reset release; InstrValid=1 with Instruction = memory word; PCPlus4=0x104.
- Sequential fetch, PCSel=00, Stall=0 → addresses 0x100, 0x104, 0x108 at one request per 3 cycles.
- PC=0x200, PCSel=01, Immediate=32'hFFFF_FFF0 → next IMemAddr=0x1F0. PCSel=10, JalrTarget=0x00000305 → next IMemAddr=0x304.
- Stall held high 5 cycles in VALID, then memory wait of 4 cycles → no new IMemReq and stable PC/Instruction during stall; InstrValid low until IMemValid arrives.
- PCSel=01, Immediate=0x6 from PC=0x100 → MisalignFault=1, PC stays 0x100, no further IMemReq until reset.
- Reset asserted during WAIT → outputs return to reset values that cycle (Instruction=0x00000013); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage: next-PC selector,
// fetch FSM states and the canonical NOP used as the reset instruction.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_JALR  = 2'b10,
    PC_RSVD  = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection and alignment check. Purely combinational; the
// fetch FSM decides whether the result is committed.
module pc_next_mux
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_sel_e     pc_sel,
  input  logic [31:0] immediate,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc_next,
  output logic        misaligned
);

  // Select the redirect target; JALR clears bit 0, the reserved code falls back to PC+4
  always_comb begin
    pc_next = pc + 32'd4;
    case (pc_sel)
      PC_IMM:  pc_next = pc + immediate;
      PC_JALR: pc_next = {jalr_target[31:1], 1'b0};
      default: pc_next = pc + 32'd4;
    endcase
    misaligned = (pc_next[1:0] != 2'b00);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues one read at a time to instruction
// memory and holds the fetched word for decode until the core retires it.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSel,
  input  logic [31:0] Immediate,
  input  logic [31:0] JalrTarget,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignFault
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic         fault_reg;
  logic [31:0]  pc_next;
  logic         misaligned;
  logic         retire;

  pc_next_mux u_pc_next_mux (
    .pc          (pc_reg),
    .pc_sel      (pc_sel_e'(PCSel)),
    .immediate   (Immediate),
    .jalr_target (JalrTarget),
    .pc_next     (pc_next),
    .misaligned  (misaligned)
  );

  // The core takes the instruction on the edge where it is valid and not stalled
  assign retire = (state_reg == ST_VALID) && !Stall;

  // Fetch sequencing: request, wait for data, present, then retire or halt on a bad target
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  state_next = ST_REQ;
      ST_REQ:   state_next = ST_WAIT;
      ST_WAIT:  if (IMemValid) state_next = ST_VALID;
      ST_VALID: if (retire) state_next = misaligned ? ST_HALT : ST_REQ;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, PC, instruction and fault registers; responses only land while waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_WAIT) && IMemValid) begin
        instr_reg <= IMemRData;
      end
      if (retire && !misaligned) begin
        pc_reg <= pc_next;
      end
      if (retire && misaligned) begin
        fault_reg <= 1'b1;
      end
    end
  end

  assign IMemReq       = (state_reg == ST_REQ);
  assign IMemAddr      = pc_reg;
  assign Instruction   = instr_reg;
  assign InstrValid    = (state_reg == ST_VALID);
  assign PC            = pc_reg;
  assign PCPlus4       = pc_reg + 32'd4;
  assign MisalignFault = fault_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for the fetch unit. A memory responder with random
// latency and a core with random stalls/redirects drive the DUT; a
// transaction-level model tracks the expected PC, instruction and
// handshake timing.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  PCSel = 2'b00;
  logic [31:0] Immediate = 32'h0;
  logic [31:0] JalrTarget = 32'h0;
  logic        Stall = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid = 1'b0;
  logic [31:0] IMemRData = 32'h0;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignFault;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCSel         (PCSel),
    .Immediate     (Immediate),
    .JalrTarget    (JalrTarget),
    .Stall         (Stall),
    .IMemReq       (IMemReq),
    .IMemAddr      (IMemAddr),
    .IMemValid     (IMemValid),
    .IMemRData     (IMemRData),
    .Instruction   (Instruction),
    .InstrValid    (InstrValid),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .MisalignFault (MisalignFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] jt;
  } redir_t;

  redir_t      force_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_retire = 0;

  // Reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] load_instr;
  bit          load_due;
  bit          exp_fault;
  bit          req_due;
  bit          iv_due;
  bit          pending;
  int          cnt;
  logic [31:0] pend_addr;

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Assert reset at a falling edge, check reset values, release two cycles later
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    IMemValid = 1'b0;
    #1;
    check_val("rst_Instruction", Instruction, NOP);
    check_val("rst_InstrValid", {31'b0, InstrValid}, 32'd0);
    check_val("rst_IMemReq", {31'b0, IMemReq}, 32'd0);
    check_val("rst_PC", PC, RST_PC);
    check_val("rst_Fault", {31'b0, MisalignFault}, 32'd0);
    exp_pc = RST_PC; exp_instr = NOP; load_due = 0; exp_fault = 0;
    req_due = 0; iv_due = 0; pending = 0; cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_due = 1;
  endtask

  // One clock cycle: check outputs against the model, then drive memory and core
  task automatic step(input bit allow_mis);
    bit          exp_req, exp_iv;
    logic [1:0]  sel;
    logic [31:0] imm, jt, nxt;
    redir_t      r;
    @(negedge clk);
    exp_req = req_due; req_due = 0;
    exp_iv  = iv_due;  iv_due = 0;
    if (load_due) begin exp_instr = load_instr; load_due = 0; end
    check_val("IMemReq", {31'b0, IMemReq}, {31'b0, exp_req});
    check_val("InstrValid", {31'b0, InstrValid}, {31'b0, exp_iv});
    check_val("Fault", {31'b0, MisalignFault}, {31'b0, exp_fault});
    check_val("PC", PC, exp_pc);
    check_val("PCPlus4", PCPlus4, exp_pc + 32'd4);
    check_val("Instruction", Instruction, exp_instr);

    // Memory side
    IMemValid = 1'b0;
    IMemRData = $urandom;
    if (IMemReq) begin
      check_val("IMemAddr", IMemAddr, exp_pc);
      pending = 1; cnt = $urandom_range(1, 4); pend_addr = exp_pc;
    end else if (pending) begin
      cnt--;
      if (cnt == 0) begin
        IMemValid = 1'b1;
        IMemRData = mem_word(pend_addr);
        pending = 0; iv_due = 1;
        load_due = 1; load_instr = mem_word(pend_addr);
      end
    end else if ($urandom_range(0, 3) == 0) begin
      IMemValid = 1'b1;   // stray response, must be ignored
    end

    // Core side: redirect inputs are garbage except on the retiring edge
    Stall      = ($urandom_range(0, 2) == 0);
    PCSel      = 2'($urandom);
    Immediate  = $urandom;
    JalrTarget = $urandom;
    if (InstrValid) begin
      if (Stall) begin
        iv_due = 1;
      end else begin
        if (force_q.size() > 0) begin
          r = force_q.pop_front();
          sel = r.sel; imm = r.imm; jt = r.jt;
        end else begin
          sel = 2'($urandom);
          imm = $urandom_range(0, 1) ? ($urandom & 32'h0000_0FFC) : ($urandom | 32'hFFFF_F000) & 32'hFFFF_FFFC;
          jt  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFD);
          if (allow_mis && $urandom_range(0, 7) == 0) imm[1:0] = 2'($urandom);
          if (allow_mis && $urandom_range(0, 7) == 0) jt[1] = 1'b1;
        end
        PCSel = sel; Immediate = imm; JalrTarget = jt;
        if (sel == 2'b01)      nxt = exp_pc + imm;
        else if (sel == 2'b10) nxt = jt & 32'hFFFF_FFFE;
        else                   nxt = exp_pc + 32'd4;
        n_retire++;
        $display("retire pc=%h instr=%h sel=%0d next=%h%s", exp_pc, exp_instr, sel, nxt,
                 (nxt[1:0] != 2'b00) ? " misaligned" : "");
        if (nxt[1:0] != 2'b00) exp_fault = 1;
        else begin exp_pc = nxt; req_due = 1; end
      end
    end
  endtask

  task automatic run_retires(input int target, input bit allow_mis, input int budget);
    int c;
    c = 0;
    while (n_retire < target && c < budget) begin
      step(allow_mis);
      c++;
    end
    check_val("retire_budget", {31'b0, (n_retire >= target)}, 32'd1);
  endtask

  initial begin
    int c;
    // Reset values and directed redirects from the reset PC
    do_reset();
    force_q.push_back('{2'b00, 32'h0, 32'h0});          // 0x100 -> 0x104
    force_q.push_back('{2'b11, 32'h0, 32'h0});          // 0x104 -> 0x108 (reserved)
    force_q.push_back('{2'b01, 32'h0000_00F8, 32'h0});  // 0x108 -> 0x200
    force_q.push_back('{2'b01, 32'hFFFF_FFF0, 32'h0});  // 0x200 -> 0x1F0
    force_q.push_back('{2'b10, 32'h0, 32'h0000_0305});  // 0x1F0 -> 0x304
    force_q.push_back('{2'b10, 32'h0, 32'hFFFF_FFFD});  // -> 0xFFFFFFFC
    force_q.push_back('{2'b00, 32'h0, 32'h0});          // wraps to 0
    force_q.push_back('{2'b00, 32'h0, 32'h0});          // 0 -> 4
    run_retires(8, 1'b0, 400);

    // Random aligned traffic
    run_retires(100, 1'b0, 4000);

    // Reset while a read is outstanding
    c = 0;
    while (!(pending && cnt >= 2) && c < 100) begin
      step(1'b0);
      c++;
    end
    check_val("found_wait", {31'b0, pending}, 32'd1);
    do_reset();
    run_retires(n_retire + 3, 1'b0, 200);

    // Misaligned branch from the reset PC halts the unit
    do_reset();
    force_q.push_back('{2'b01, 32'h0000_0006, 32'h0});
    run_retires(n_retire + 1, 1'b0, 50);
    repeat (15) step(1'b0);
    check_val("halt_fault", {31'b0, MisalignFault}, 32'd1);
    check_val("halt_pc", PC, RST_PC);

    // Random traffic including faults, recovered by reset
    for (int k = 0; k < 3; k++) begin
      do_reset();
      repeat (200) step(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
